// File: rtl/hazard_stall_sequencer.sv
// Fetch/decode stall sequencer: decodes the opcode in decode and holds PC / IR for
// loads, jumps and HALT, with parameterised stall lengths and a saturating stall counter.
module hazard_stall_sequencer #(
  parameter int LD_STALL  = 1,
  parameter int JMP_STALL = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             resume,
  output logic             stall,
  output logic             stall_pm,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam logic [5:0] OP_HLT   = 6'b010001;
  localparam logic [5:0] OP_LD    = 6'b010100;
  localparam logic [3:0] LD_INIT  = 4'(LD_STALL - 1);
  localparam logic [3:0] JMP_INIT = 4'(JMP_STALL - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             stall_pm_q;
  logic [CNT_W-1:0] count_q;

  logic is_hlt, is_ld, is_jmp;

  assign is_hlt = (op == OP_HLT);
  assign is_ld  = (op == OP_LD);
  assign is_jmp = (op[5] == 1'b0) && (op[4:2] == 3'b111);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall = is_hlt | is_ld | is_jmp;
        if (is_hlt) begin
          state_d = ST_HALT;
        end else if (is_ld) begin
          cnt_d   = LD_INIT;
          state_d = (LD_INIT != 4'd0) ? ST_STALL : ST_RELEASE;
        end else if (is_jmp) begin
          cnt_d   = JMP_INIT;
          state_d = (JMP_INIT != 4'd0) ? ST_STALL : ST_RELEASE;
        end
      end
      ST_STALL: begin
        stall = 1'b1;
        cnt_d = cnt_q - 4'd1;
        // <= 1 rather than == 1 so a corrupted zero count cannot wrap into a 15-cycle stall
        if (cnt_q <= 4'd1) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
      end
      ST_HALT: begin
        stall = 1'b1;
        if (resume) state_d = ST_RELEASE;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      cnt_q      <= 4'd0;
      stall_pm_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stall_pm_q <= stall;
      if (stall && (count_q != {CNT_W{1'b1}})) count_q <= count_q + CNT_W'(1);
    end
  end

  assign stall_pm    = stall_pm_q;
  assign halted      = (state_q == ST_HALT);
  assign busy        = (state_q != ST_RUN);
  assign stall_count = count_q;

endmodule
